// File: rtl/wishbone_decoder.sv
// wishbone_decoder
//   Single-manager to multi-subordinate Wishbone address decoder. Each
//   manager request goes to exactly one subordinate, chosen by base/mask
//   match with the lowest index winning on overlap. An unmapped address gets
//   a one-cycle default acknowledge with ERR_O. A transfer the subordinate
//   never acknowledges can be force-acked after TIMEOUT_CYCLES ACTIVE cycles,
//   so the manager bus cannot deadlock.
//
// Build option:
//   WB_DECODER_TIMEOUT_EN  defined   -> timeout counter and forced ack present
//                          undefined -> ACTIVE waits for ack or manager abort;
//                                       TIMEOUT_CYCLES is only range-checked
//
// Ports:
//   CLK, nRST                   clock, asynchronous active-low reset
//   ADR_I, DAT_I, SEL_I         manager address, write data, byte selects
//   WE_I, STB_I, CYC_I          manager control
//   DAT_O, ACK_O, ERR_O         read data, ack, default-ack flag to manager
//   S_ADR_O, S_DAT_O, S_SEL_O   per-subordinate address/data/selects (flat)
//   S_WE_O, S_STB_O, S_CYC_O    per-subordinate control
//   S_DAT_I, S_ACK_I            subordinate read data and acks (flat)
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | no transfer open; a hit is forwarded combinationally
// ACTIVE      | transfer open on subordinate sel, waiting for its ack
// DEFAULT_ACK | one-cycle ack with DEFAULT_DATA and ERR_O (unmapped/timeout)
module wishbone_decoder #(
  parameter int                             NUM_SUBORDINATES = 4,
  parameter logic [32*NUM_SUBORDINATES-1:0] BASE_ADDRS       = {32'h3000_3000, 32'h3000_2000,
                                                                32'h3000_1000, 32'h3000_0000},
  parameter logic [32*NUM_SUBORDINATES-1:0] ADDR_MASKS       = {NUM_SUBORDINATES{32'hFFFF_F000}},
  parameter int                             TIMEOUT_CYCLES   = 255,
  parameter logic [31:0]                    DEFAULT_DATA     = 32'hBAD0_BAD0
) (
  input  logic                               CLK,
  input  logic                               nRST,
  input  logic [31:0]                        ADR_I,
  input  logic [31:0]                        DAT_I,
  input  logic [3:0]                         SEL_I,
  input  logic                               WE_I,
  input  logic                               STB_I,
  input  logic                               CYC_I,
  output logic [31:0]                        DAT_O,
  output logic                               ACK_O,
  output logic                               ERR_O,
  output logic [32*NUM_SUBORDINATES-1:0]     S_ADR_O,
  output logic [32*NUM_SUBORDINATES-1:0]     S_DAT_O,
  output logic [4*NUM_SUBORDINATES-1:0]      S_SEL_O,
  output logic [NUM_SUBORDINATES-1:0]        S_WE_O,
  output logic [NUM_SUBORDINATES-1:0]        S_STB_O,
  output logic [NUM_SUBORDINATES-1:0]        S_CYC_O,
  input  logic [32*NUM_SUBORDINATES-1:0]     S_DAT_I,
  input  logic [NUM_SUBORDINATES-1:0]        S_ACK_I
);

  localparam int N     = NUM_SUBORDINATES;
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  if (NUM_SUBORDINATES < 1 || NUM_SUBORDINATES > 16) begin : g_bad_num
    $error("wishbone_decoder: NUM_SUBORDINATES must be 1..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("wishbone_decoder: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ACTIVE      = 2'd1,
    DEFAULT_ACK = 2'd2
  } state_t;

  state_t           state, next_state;
  logic [SEL_W-1:0] sel;
  logic             req;
  logic             hit_any;
  logic [SEL_W-1:0] hit_idx;
  logic             route_en;
  logic [SEL_W-1:0] route_idx;
  logic [31:0]      sub_dat;
  logic             sub_ack;
  logic             timeout;

  assign req = STB_I & CYC_I;

  // Scan from the top down so the lowest matching index is the one left.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if ((ADR_I & ADDR_MASKS[k*32 +: 32]) ==
          (BASE_ADDRS[k*32 +: 32] & ADDR_MASKS[k*32 +: 32])) begin
        hit_any = 1'b1;
        hit_idx = SEL_W'(k);
      end
    end
  end

  // Which port (if any) is connected to the manager this cycle. Gated by
  // nRST so subordinate strobes drop as soon as reset is asserted, even if
  // the manager is still holding its request.
  always_comb begin
    route_en  = 1'b0;
    route_idx = sel;
    if (nRST) begin
      case (state)
        IDLE: begin
          route_en  = req & hit_any;
          route_idx = hit_idx;
        end
        ACTIVE:  route_en = req;
        default: route_en = 1'b0;
      endcase
    end
  end

  // Only the routed port's ack/data are ever looked at.
  always_comb begin
    sub_dat = '0;
    sub_ack = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (route_idx == SEL_W'(k)) begin
        sub_dat = S_DAT_I[k*32 +: 32];
        sub_ack = S_ACK_I[k];
      end
    end
  end

`ifdef WB_DECODER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (state == ACTIVE && req && !sub_ack) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      sel   <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && req && hit_any) begin
        sel <= hit_idx;
      end
    end
  end

  // An ack in the expiry cycle takes priority over the forced ack.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (!hit_any)     next_state = DEFAULT_ACK;
          else if (sub_ack) next_state = IDLE;
          else              next_state = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!req || sub_ack) next_state = IDLE;
        else if (timeout)    next_state = DEFAULT_ACK;
      end
      DEFAULT_ACK: next_state = IDLE;
      default:     next_state = IDLE;
    endcase
  end

  always_comb begin
    S_ADR_O = '0;
    S_DAT_O = '0;
    S_SEL_O = '0;
    S_WE_O  = '0;
    S_STB_O = '0;
    S_CYC_O = '0;
    ACK_O   = 1'b0;
    DAT_O   = '0;
    ERR_O   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (route_en && route_idx == SEL_W'(k)) begin
        S_ADR_O[k*32 +: 32] = ADR_I;
        S_DAT_O[k*32 +: 32] = DAT_I;
        S_SEL_O[k*4 +: 4]   = SEL_I;
        S_WE_O[k]           = WE_I;
        S_STB_O[k]          = STB_I;
        S_CYC_O[k]          = CYC_I;
      end
    end
    if (route_en && sub_ack) begin
      ACK_O = 1'b1;
      DAT_O = sub_dat;
    end else if (nRST && state == DEFAULT_ACK) begin
      ACK_O = 1'b1;
      DAT_O = DEFAULT_DATA;
      ERR_O = 1'b1;
    end
  end

endmodule

// File: tb/tb_wishbone_decoder.sv
module tb_wishbone_decoder;

  logic         CLK = 1'b0;
  logic         nRST;
  logic [31:0]  ADR_I, DAT_I;
  logic [3:0]   SEL_I;
  logic         WE_I, STB_I, CYC_I;
  logic [31:0]  DAT_O;
  logic         ACK_O, ERR_O;
  logic [127:0] S_ADR_O, S_DAT_O, S_DAT_I;
  logic [15:0]  S_SEL_O;
  logic [3:0]   S_WE_O, S_STB_O, S_CYC_O, S_ACK_I;

  // second instance with an overlapping map (both ports at 0x3000_0000)
  logic [31:0]  ov_dat_o;
  logic         ov_ack_o, ov_err_o;
  logic [63:0]  ov_adr_o, ov_wdat_o, ov_dat_i;
  logic [7:0]   ov_sel_o;
  logic [1:0]   ov_we_o, ov_stb_o, ov_cyc_o, ov_ack_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  wishbone_decoder #(
    .NUM_SUBORDINATES(4),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .ADR_I(ADR_I), .DAT_I(DAT_I), .SEL_I(SEL_I),
    .WE_I(WE_I), .STB_I(STB_I), .CYC_I(CYC_I),
    .DAT_O(DAT_O), .ACK_O(ACK_O), .ERR_O(ERR_O),
    .S_ADR_O(S_ADR_O), .S_DAT_O(S_DAT_O), .S_SEL_O(S_SEL_O),
    .S_WE_O(S_WE_O), .S_STB_O(S_STB_O), .S_CYC_O(S_CYC_O),
    .S_DAT_I(S_DAT_I), .S_ACK_I(S_ACK_I)
  );

  wishbone_decoder #(
    .NUM_SUBORDINATES(2),
    .BASE_ADDRS({32'h3000_0000, 32'h3000_0000}),
    .ADDR_MASKS({2{32'hFFFF_F000}}),
    .TIMEOUT_CYCLES(4)
  ) dut_ov (
    .CLK(CLK), .nRST(nRST),
    .ADR_I(ADR_I), .DAT_I(DAT_I), .SEL_I(SEL_I),
    .WE_I(WE_I), .STB_I(STB_I), .CYC_I(CYC_I),
    .DAT_O(ov_dat_o), .ACK_O(ov_ack_o), .ERR_O(ov_err_o),
    .S_ADR_O(ov_adr_o), .S_DAT_O(ov_wdat_o), .S_SEL_O(ov_sel_o),
    .S_WE_O(ov_we_o), .S_STB_O(ov_stb_o), .S_CYC_O(ov_cyc_o),
    .S_DAT_I(ov_dat_i), .S_ACK_I(ov_ack_i)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus(input logic [31:0] adr, input logic [31:0] dat,
                     input logic we, input logic req);
    ADR_I = adr;
    DAT_I = dat;
    WE_I  = we;
    SEL_I = 4'hF;
    STB_I = req;
    CYC_I = req;
  endtask

  task automatic test_reset();
    nRST     = 1'b0;
    bus(32'h0, 32'h0, 1'b0, 1'b0);
    S_ACK_I  = 4'b0000;
    S_DAT_I  = {32'h3333_0003, 32'h2222_2222, 32'h1234_5678, 32'hCAFE_0000};
    ov_ack_i = 2'b00;
    ov_dat_i = {32'h1111_1111, 32'h0000_0B0B};
    #2;
    n_checks++; if ({ACK_O, ERR_O} !== 2'b00) begin n_fail++; $display("FAIL rst_ack_err got %b exp 00", {ACK_O, ERR_O}); end
    n_checks++; if (DAT_O !== 32'h0) begin n_fail++; $display("FAIL rst_dat got %h exp 0", DAT_O); end
    n_checks++; if ({S_STB_O, S_CYC_O, S_WE_O} !== 12'h000) begin n_fail++; $display("FAIL rst_ctl got %h exp 000", {S_STB_O, S_CYC_O, S_WE_O}); end
    n_checks++; if (S_ADR_O !== 128'h0) begin n_fail++; $display("FAIL rst_adr got %h exp 0", S_ADR_O); end
    step();
    step();
    nRST = 1'b1;
    step();
    #3;
    n_checks++; if ({ACK_O, ERR_O, S_STB_O} !== 6'h00) begin n_fail++; $display("FAIL rst_idle got %b exp 000000", {ACK_O, ERR_O, S_STB_O}); end
  endtask

  task automatic test_mapped_read();
    logic [3:0]   exp_stb;
    logic         exp_ack;
    logic [31:0]  exp_dat;
    logic [127:0] exp_adr;
    for (int c = 0; c < 4; c++) begin
      step();
      bus(32'h3000_1004, 32'h0, 1'b0, c < 3);
      // sub2 acking in cycle 1 is not selected and must be ignored
      S_ACK_I = (c == 2) ? 4'b0010 : (c == 1) ? 4'b0100 : 4'b0000;
      #3;
      exp_stb = (c < 3) ? 4'b0010 : 4'b0000;
      exp_ack = (c == 2);
      exp_dat = (c == 2) ? 32'h1234_5678 : 32'h0;
      exp_adr = (c < 3) ? {64'h0, 32'h3000_1004, 32'h0} : 128'h0;
      n_checks++; if (S_STB_O !== exp_stb) begin n_fail++; $display("FAIL rd_stb c=%0d got %b exp %b", c, S_STB_O, exp_stb); end
      n_checks++; if (ACK_O !== exp_ack) begin n_fail++; $display("FAIL rd_ack c=%0d got %b exp %b", c, ACK_O, exp_ack); end
      n_checks++; if (DAT_O !== exp_dat) begin n_fail++; $display("FAIL rd_dat c=%0d got %h exp %h", c, DAT_O, exp_dat); end
      n_checks++; if (ERR_O !== 1'b0) begin n_fail++; $display("FAIL rd_err c=%0d got %b exp 0", c, ERR_O); end
      n_checks++; if (S_ADR_O !== exp_adr) begin n_fail++; $display("FAIL rd_adr c=%0d got %h exp %h", c, S_ADR_O, exp_adr); end
    end
  endtask

  task automatic test_back_to_back();
    step();
    bus(32'h3000_0000, 32'hA5A5_A5A5, 1'b1, 1'b1);
    S_ACK_I = 4'b0001;
    #3;
    n_checks++; if (S_DAT_O !== {96'h0, 32'hA5A5_A5A5}) begin n_fail++; $display("FAIL wr_dat got %h exp a5a5a5a5 in slot 0", S_DAT_O); end
    n_checks++; if (S_SEL_O !== 16'h000F) begin n_fail++; $display("FAIL wr_sel got %h exp 000f", S_SEL_O); end
    n_checks++; if ({S_WE_O, S_STB_O} !== 8'b0001_0001) begin n_fail++; $display("FAIL wr_we_stb got %b exp 00010001", {S_WE_O, S_STB_O}); end
    n_checks++; if ({ACK_O, ERR_O} !== 2'b10) begin n_fail++; $display("FAIL wr_ack got %b exp 10", {ACK_O, ERR_O}); end
    n_checks++; if (DAT_O !== 32'hCAFE_0000) begin n_fail++; $display("FAIL wr_rdat got %h exp cafe0000", DAT_O); end
    step();
    bus(32'h3000_3010, 32'h0, 1'b0, 1'b1);
    S_ACK_I = 4'b1000;
    #3;
    n_checks++; if ({S_WE_O, S_STB_O} !== 8'b0000_1000) begin n_fail++; $display("FAIL b2b_stb got %b exp 00001000", {S_WE_O, S_STB_O}); end
    n_checks++; if (ACK_O !== 1'b1) begin n_fail++; $display("FAIL b2b_ack got %b exp 1", ACK_O); end
    n_checks++; if (DAT_O !== 32'h3333_0003) begin n_fail++; $display("FAIL b2b_dat got %h exp 33330003", DAT_O); end
    step();
    bus(32'h0, 32'h0, 1'b0, 1'b0);
    S_ACK_I = 4'b0000;
    #3;
    n_checks++; if ({ACK_O, S_STB_O} !== 5'b0) begin n_fail++; $display("FAIL b2b_idle got %b exp 00000", {ACK_O, S_STB_O}); end
  endtask

  task automatic test_unmapped();
    logic        exp_ack;
    logic [31:0] exp_dat;
    for (int c = 0; c < 3; c++) begin
      step();
      bus(32'h4000_0000, 32'h0, 1'b0, c < 2);
      #3;
      exp_ack = (c == 1);
      exp_dat = (c == 1) ? 32'hBAD0_BAD0 : 32'h0;
      n_checks++; if ({S_STB_O, S_CYC_O} !== 8'h00) begin n_fail++; $display("FAIL um_stb c=%0d got %b exp 0", c, {S_STB_O, S_CYC_O}); end
      n_checks++; if ({ACK_O, ERR_O} !== {exp_ack, exp_ack}) begin n_fail++; $display("FAIL um_ack_err c=%0d got %b exp %b", c, {ACK_O, ERR_O}, {exp_ack, exp_ack}); end
      n_checks++; if (DAT_O !== exp_dat) begin n_fail++; $display("FAIL um_dat c=%0d got %h exp %h", c, DAT_O, exp_dat); end
    end
  endtask

  task automatic test_timeout();
    logic [3:0]  exp_stb;
    logic        exp_ack, exp_err;
    logic [31:0] exp_dat;
`ifdef WB_DECODER_TIMEOUT_EN
    // sub2 never acks: strobe cycles 0-4, forced ack in cycle 5
    for (int c = 0; c < 7; c++) begin
      step();
      bus(32'h3000_2000, 32'h0, 1'b0, c <= 5);
      S_ACK_I = 4'b0000;
      #3;
      exp_stb = (c <= 4) ? 4'b0100 : 4'b0000;
      exp_ack = (c == 5);
      exp_err = (c == 5);
      exp_dat = (c == 5) ? 32'hBAD0_BAD0 : 32'h0;
      n_checks++; if (S_STB_O !== exp_stb) begin n_fail++; $display("FAIL to_stb c=%0d got %b exp %b", c, S_STB_O, exp_stb); end
      n_checks++; if ({ACK_O, ERR_O} !== {exp_ack, exp_err}) begin n_fail++; $display("FAIL to_ack_err c=%0d got %b exp %b", c, {ACK_O, ERR_O}, {exp_ack, exp_err}); end
      n_checks++; if (DAT_O !== exp_dat) begin n_fail++; $display("FAIL to_dat c=%0d got %h exp %h", c, DAT_O, exp_dat); end
    end
    // sub2 acks in the expiry cycle: normal ack, no forced ack afterwards
    for (int c = 0; c < 6; c++) begin
      step();
      bus(32'h3000_2000, 32'h0, 1'b0, c <= 4);
      S_ACK_I = (c == 4) ? 4'b0100 : 4'b0000;
      #3;
      exp_stb = (c <= 4) ? 4'b0100 : 4'b0000;
      exp_ack = (c == 4);
      exp_dat = (c == 4) ? 32'h2222_2222 : 32'h0;
      n_checks++; if (S_STB_O !== exp_stb) begin n_fail++; $display("FAIL tack_stb c=%0d got %b exp %b", c, S_STB_O, exp_stb); end
      n_checks++; if ({ACK_O, ERR_O} !== {exp_ack, 1'b0}) begin n_fail++; $display("FAIL tack_ack_err c=%0d got %b exp %b", c, {ACK_O, ERR_O}, {exp_ack, 1'b0}); end
      n_checks++; if (DAT_O !== exp_dat) begin n_fail++; $display("FAIL tack_dat c=%0d got %h exp %h", c, DAT_O, exp_dat); end
    end
`else
    // no timeout: ACTIVE holds for as long as the manager keeps the request
    for (int c = 0; c < 21; c++) begin
      step();
      bus(32'h3000_2000, 32'h0, 1'b0, c < 20);
      S_ACK_I = 4'b0000;
      #3;
      exp_stb = (c < 20) ? 4'b0100 : 4'b0000;
      n_checks++; if (S_STB_O !== exp_stb) begin n_fail++; $display("FAIL nto_stb c=%0d got %b exp %b", c, S_STB_O, exp_stb); end
      n_checks++; if ({ACK_O, ERR_O} !== 2'b00) begin n_fail++; $display("FAIL nto_ack_err c=%0d got %b exp 00", c, {ACK_O, ERR_O}); end
    end
`endif
  endtask

  task automatic test_abort();
    logic [3:0]  exp_stb;
    logic        exp_ack;
    logic [31:0] exp_dat;
    for (int c = 0; c < 5; c++) begin
      step();
      if (c < 2)       bus(32'h3000_3000, 32'h0, 1'b0, 1'b1);
      else if (c == 3) bus(32'h3000_0000, 32'h0, 1'b0, 1'b1);
      else             bus(32'h3000_3000, 32'h0, 1'b0, 1'b0);
      if (c == 2) STB_I = 1'b1;
      S_ACK_I = (c == 3) ? 4'b0001 : 4'b0000;
      #3;
      exp_stb = (c < 2) ? 4'b1000 : (c == 3) ? 4'b0001 : 4'b0000;
      exp_ack = (c == 3);
      exp_dat = (c == 3) ? 32'hCAFE_0000 : 32'h0;
      n_checks++; if (S_CYC_O !== exp_stb) begin n_fail++; $display("FAIL ab_cyc c=%0d got %b exp %b", c, S_CYC_O, exp_stb); end
      n_checks++; if (S_STB_O !== exp_stb) begin n_fail++; $display("FAIL ab_stb c=%0d got %b exp %b", c, S_STB_O, exp_stb); end
      n_checks++; if ({ACK_O, ERR_O} !== {exp_ack, 1'b0}) begin n_fail++; $display("FAIL ab_ack c=%0d got %b exp %b", c, {ACK_O, ERR_O}, {exp_ack, 1'b0}); end
      n_checks++; if (DAT_O !== exp_dat) begin n_fail++; $display("FAIL ab_dat c=%0d got %h exp %h", c, DAT_O, exp_dat); end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 2; c++) begin
      step();
      bus(32'h3000_1000, 32'h0, 1'b0, 1'b1);
      S_ACK_I = 4'b0000;
      #3;
      n_checks++; if (S_STB_O !== 4'b0010) begin n_fail++; $display("FAIL rm_pre c=%0d got %b exp 0010", c, S_STB_O); end
    end
    step();
    #1;
    nRST = 1'b0;
    #1;
    n_checks++; if ({S_STB_O, S_CYC_O} !== 8'h00) begin n_fail++; $display("FAIL rm_ctl got %b exp 0", {S_STB_O, S_CYC_O}); end
    n_checks++; if ({ACK_O, ERR_O} !== 2'b00) begin n_fail++; $display("FAIL rm_ack got %b exp 00", {ACK_O, ERR_O}); end
    n_checks++; if (DAT_O !== 32'h0) begin n_fail++; $display("FAIL rm_dat got %h exp 0", DAT_O); end
    step();
    bus(32'h0, 32'h0, 1'b0, 1'b0);
    nRST = 1'b1;
    // a stale ACTIVE/sel=1 would keep routing to sub1
    step();
    bus(32'h3000_0000, 32'h0, 1'b0, 1'b1);
    #3;
    n_checks++; if (S_STB_O !== 4'b0001) begin n_fail++; $display("FAIL rm_post got %b exp 0001", S_STB_O); end
    step();
    bus(32'h0, 32'h0, 1'b0, 1'b0);
    #3;
    n_checks++; if (S_STB_O !== 4'b0000) begin n_fail++; $display("FAIL rm_idle got %b exp 0000", S_STB_O); end
  endtask

  task automatic test_overlap();
    logic        exp_ack;
    logic [31:0] exp_dat;
    logic [1:0]  exp_stb;
    for (int c = 0; c < 4; c++) begin
      step();
      bus(32'h3000_0008, 32'h0, 1'b0, c < 3);
      S_ACK_I  = 4'b0000;
      ov_ack_i = (c == 1) ? 2'b10 : (c == 2) ? 2'b01 : 2'b00;
      #3;
      exp_stb = (c < 3) ? 2'b01 : 2'b00;
      exp_ack = (c == 2);
      exp_dat = (c == 2) ? 32'h0000_0B0B : 32'h0;
      n_checks++; if (ov_stb_o !== exp_stb) begin n_fail++; $display("FAIL ov_stb c=%0d got %b exp %b", c, ov_stb_o, exp_stb); end
      n_checks++; if ({ov_ack_o, ov_err_o} !== {exp_ack, 1'b0}) begin n_fail++; $display("FAIL ov_ack c=%0d got %b exp %b", c, {ov_ack_o, ov_err_o}, {exp_ack, 1'b0}); end
      n_checks++; if (ov_dat_o !== exp_dat) begin n_fail++; $display("FAIL ov_dat c=%0d got %h exp %h", c, ov_dat_o, exp_dat); end
    end
  endtask

  initial begin
    test_reset();
    test_mapped_read();
    test_back_to_back();
    test_unmapped();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_overlap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
